// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point DCT-II / IDCT engine.
// Provides:
//   - default widths;
//   - vector typedefs;
//   - the integer cosine table generator coef(k, n, frac);
//   - the output saturation helper.
// The cosine table is built from a Q30 table of cos(i*pi/16), so it is
// pure integer arithmetic and resolves at elaboration.
package dct_pkg;

    localparam int NPT           = 8;
    localparam int IN_W_DEF      = 9;
    localparam int OUT_W_DEF     = 12;
    localparam int COEF_FRAC_DEF = 12;
    localparam int TAG_W_DEF     = 3;
    localparam int ACC_W_DEF     = IN_W_DEF + COEF_FRAC_DEF + 4;

    typedef logic signed [IN_W_DEF-1:0]  sample_t;
    typedef sample_t     [NPT-1:0]       sample_vec_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;
    typedef acc_t        [NPT-1:0]       acc_vec_t;

    // cos(m*pi/16) scaled by 2^30, folded onto the first quadrant.
    function automatic longint cos_q30(input int m);
        int     mm;
        int     idx;
        logic   neg;
        longint v;
        mm = m % 32;
        if (mm <= 8) begin
            idx = mm;
            neg = 1'b0;
        end else if (mm <= 16) begin
            idx = 16 - mm;
            neg = 1'b1;
        end else if (mm <= 24) begin
            idx = mm - 16;
            neg = 1'b1;
        end else begin
            idx = 32 - mm;
            neg = 1'b0;
        end
        case (idx)
            0:       v = 64'd1073741824;
            1:       v = 64'd1053110176;
            2:       v = 64'd992008094;
            3:       v = 64'd892783698;
            4:       v = 64'd759250125;
            5:       v = 64'd596538995;
            6:       v = 64'd410903206;
            7:       v = 64'd209476638;
            default: v = 64'd0;
        endcase
        return neg ? -v : v;
    endfunction

    // C[k][n] = round_half_away(2^frac * a(k)/2 * cos((2n+1)k*pi/16)).
    // The a(0) = 1/sqrt(2) factor equals cos(4*pi/16).
    function automatic int coef(input int k, input int n, input int frac);
        longint c;
        longint mag;
        longint r;
        c   = (k == 0) ? cos_q30(4) : cos_q30((2 * n + 1) * k);
        mag = (c < 0) ? -c : c;
        r   = ((mag <<< frac) + (longint'(1) <<< 30)) >>> 31;
        return int'((c < 0) ? -r : r);
    endfunction

    // Clip to the signed range of a w-bit value.
    function automatic longint saturate(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dct8_pipe_if.sv
// Streaming interface of dct8_pipe.
// Ports:
//   - Input side: in_valid/in_ready handshake; in_data (8 samples); in_inv (mode); in_tag.
//   - Output side: out_valid/out_ready handshake; out_data (8 coefficients); out_tag.
// Modports: master drives vectors in and consumes results; slave is the engine.
interface dct8_pipe_if
    import dct_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int TAG_W = TAG_W_DEF
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NPT-1:0][IN_W-1:0]    in_data;
    logic                        in_inv;
    logic [TAG_W-1:0]            in_tag;
    logic                        out_valid;
    logic                        out_ready;
    logic [NPT-1:0][OUT_W-1:0]   out_data;
    logic [TAG_W-1:0]            out_tag;

    modport master (
        output in_valid, in_data, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/dct8_mac_row.sv
// One output lane of the DCT engine.
// Ports:
//   - clk, rst: clock and synchronous reset.
//   - en: pipeline advance enable.
//   - x: stage-0 sample vector.
//   - inv: mode of that vector.
//   - y: saturated result, valid with the top's stage-3 valid bit.
// Forward mode uses coefficient row C[LANE][*]. Inverse mode uses column C[*][LANE].
module dct8_mac_row
    import dct_pkg::*;
#(
    parameter int LANE      = 0,
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NPT-1:0][IN_W-1:0]   x,
    input  logic                       inv,
    output logic signed [OUT_W-1:0]    y
);
    localparam int COEF_W = COEF_FRAC + 2;
    localparam int PROD_W = IN_W + COEF_W;
    localparam int ACC_W  = IN_W + COEF_FRAC + 4;

    // Round half up at bit COEF_FRAC-1. The extra MSB keeps the bias add from wrapping.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = (ACC_W + 1)'(a) + ((ACC_W + 1)'(1) <<< (COEF_FRAC - 1));
        return ACC_W'(t >>> COEF_FRAC);
    endfunction

    logic signed [PROD_W-1:0] prod    [NPT];
    logic signed [PROD_W-1:0] prod_p1 [NPT];
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_p2;
    logic signed [ACC_W-1:0]  rnd;
    longint                   sat_val;
    logic signed [OUT_W-1:0]  y_p3;

    for (genvar j = 0; j < NPT; j++) begin : g_term
        localparam logic signed [COEF_W-1:0] CF = COEF_W'(coef(LANE, j, COEF_FRAC));
        localparam logic signed [COEF_W-1:0] CI = COEF_W'(coef(j, LANE, COEF_FRAC));
        logic signed [COEF_W-1:0] c;
        assign c       = inv ? CI : CF;
        assign prod[j] = PROD_W'($signed(x[j])) * PROD_W'(c);
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j < NPT; j++) begin
            sum = sum + ACC_W'(prod_p1[j]);
        end
    end

    always_comb begin
        rnd     = round_shift(acc_p2);
        sat_val = saturate(longint'(rnd), OUT_W);
    end

    // Stage 1: products. Stage 2: full sum.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_p1 <= prod;
            acc_p2  <= sum;
        end
    end

    // Stage 3: round and saturate into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p3 <= '0;
        end else if (en) begin
            y_p3 <= OUT_W'(sat_val);
        end
    end

    assign y = y_p3;
endmodule

// File: rtl/dct8_pipe.sv
// Pipelined 8-point 1-D DCT-II / IDCT with valid/ready backpressure.
// Ports:
//   - clk: clock.
//   - rst: synchronous active-high reset.
//   - bus: dct8_pipe_if slave.
// Behaviour:
//   - A vector accepted on in_valid && in_ready is presented four cycles later.
//   - The whole pipeline advances only when the output register is empty or being drained.
//   - in_ready is that same enable and does not depend on in_valid.
module dct8_pipe
    import dct_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int TAG_W     = TAG_W_DEF
) (
    input logic        clk,
    input logic        rst,
    dct8_pipe_if.slave bus
);
    logic                      en;
    logic                      vld_p0, vld_p1, vld_p2, vld_p3;
    logic [NPT-1:0][IN_W-1:0]  x_p0;
    logic                      inv_p0;
    logic [TAG_W-1:0]          tag_p0, tag_p1, tag_p2, tag_p3;

    assign en            = !vld_p3 || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_p3;
    assign bus.out_tag   = tag_p3;

    // Stage 0: capture the vector with its mode and tag.
    // Valids shift with the data, so bubbles propagate.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            tag_p3 <= '0;
        end else if (en) begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            tag_p3 <= tag_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            x_p0   <= bus.in_data;
            inv_p0 <= bus.in_inv;
            tag_p0 <= bus.in_tag;
            tag_p1 <= tag_p0;
            tag_p2 <= tag_p1;
        end
    end

    // Stages 1-3 live in the lanes.
    for (genvar i = 0; i < NPT; i++) begin : g_lane
        logic signed [OUT_W-1:0] y;
        dct8_mac_row #(
            .LANE      (i),
            .IN_W      (IN_W),
            .OUT_W     (OUT_W),
            .COEF_FRAC (COEF_FRAC)
        ) u_row (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .x   (x_p0),
            .inv (inv_p0),
            .y   (y)
        );
        assign bus.out_data[i] = y;
    end
endmodule

// File: tb/tb_dct8_pipe.sv
// Testbench for dct8_pipe.
// Stimulus:
//   - Table vectors with hand-derived results.
//   - Impulse sweeps.
//   - Fill and backpressure sequences.
//   - A randomized stream.
//   - Reset in mid-stream.
// Expected values come from the table or from a real-arithmetic DCT model.
// The DUT is built with IN_W=10 and OUT_W=10 so the saturation cases apply.
module tb_dct8_pipe;
    localparam int IN_W  = 10;
    localparam int OUT_W = 10;
    localparam int TAG_W = 3;
    localparam int CFRAC = 12;

    typedef struct packed {
        logic [7:0][15:0] y;
        logic [2:0]       tag;
        int               cyc;
    } exp_t;

    typedef struct packed {
        logic [7:0][15:0] x;
        logic             inv;
        logic [2:0]       tag;
        logic [7:0][15:0] y;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dct8_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

    dct8_pipe #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .COEF_FRAC (CFRAC),
        .TAG_W     (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   cref [8][8];
    exp_t q [$];
    bit   hold_vld;
    logic [7:0][OUT_W-1:0] hold_data;
    logic [TAG_W-1:0]      hold_tag;
    bit   lat_chk;
    bit   use_tbl;
    exp_t pend_exp;
    vec_t tbl [5];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_y(input logic [7:0][IN_W-1:0] xv, input bit inv, input int o);
        longint acc = 0;
        int     y;
        for (int j = 0; j < 8; j++) begin
            acc += longint'($signed(xv[j])) * longint'(inv ? cref[j][o] : cref[o][j]);
        end
        y = $rtoi($floor((real'(acc) + 2048.0) / 4096.0));
        if (y > (1 << (OUT_W - 1)) - 1) y = (1 << (OUT_W - 1)) - 1;
        if (y < -(1 << (OUT_W - 1)))    y = -(1 << (OUT_W - 1));
        return y;
    endfunction

    function automatic vec_t mk_flat(input int v, input bit inv, input int tag, input int y0);
        vec_t r;
        for (int i = 0; i < 8; i++) begin
            r.x[i] = 16'(v);
            r.y[i] = 16'(0);
        end
        r.y[0] = 16'(y0);
        r.inv  = inv;
        r.tag  = 3'(tag);
        return r;
    endfunction

    // Sample at posedge+2, register transfers, then advance to the next posedge+1.
    task automatic tick(output bit accepted);
        exp_t e;
        #1;
        accepted = bus.in_valid && bus.in_ready;
        if (hold_vld) begin
            check("hold_valid", int'(bus.out_valid), 1);
            check("hold_tag", int'(bus.out_tag), int'(hold_tag));
            for (int i = 0; i < 8; i++)
                check($sformatf("hold_y%0d", i), int'($signed(bus.out_data[i])), int'($signed(hold_data[i])));
        end
        hold_vld  = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        hold_tag  = bus.out_tag;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got out_valid=1 tag=%0d, expected no output", bus.out_tag);
            end else begin
                e = q.pop_front();
                for (int i = 0; i < 8; i++)
                    check($sformatf("y%0d", i), int'($signed(bus.out_data[i])), int'($signed(e.y[i])));
                check("tag", int'(bus.out_tag), int'(e.tag));
                if (lat_chk) check("latency", cyc - e.cyc, 4);
            end
        end
        if (accepted) begin
            if (use_tbl) e.y = pend_exp.y;
            else for (int o = 0; o < 8; o++) e.y[o] = 16'(ref_y(bus.in_data, bus.in_inv, o));
            e.tag = bus.in_tag;
            e.cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive_rand(input int tag);
        for (int i = 0; i < 8; i++) bus.in_data[i] = IN_W'(int'($urandom_range(0, 511)) - 256);
        bus.in_inv = 1'($urandom_range(0, 1));
        bus.in_tag = TAG_W'(tag);
    endtask

    initial begin
        bit acc;
        int n;
        int sent;
        int guard;
        bit have;
        real a, v;

        for (int k = 0; k < 8; k++)
            for (int m = 0; m < 8; m++) begin
                a = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                v = 4096.0 * a / 2.0 * $cos(real'((2 * m + 1) * k) * 3.14159265358979 / 16.0);
                cref[k][m] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end

        tbl[0] = mk_flat(100, 1'b0, 5, 283);
        tbl[1] = mk_flat(0, 1'b1, 2, 100);
        tbl[1].x[0] = 16'(283);
        for (int i = 0; i < 8; i++) tbl[1].y[i] = 16'(100);
        tbl[2] = mk_flat(255, 1'b0, 1, 511);
        tbl[3] = mk_flat(-256, 1'b0, 6, -512);
        tbl[4] = mk_flat(0, 1'b0, 3, 23);
        tbl[4].x[0] = 16'(64);
        tbl[4].y[1] = 16'(31); tbl[4].y[2] = 16'(30); tbl[4].y[3] = 16'(27);
        tbl[4].y[4] = 16'(23); tbl[4].y[5] = 16'(18); tbl[4].y[6] = 16'(12);
        tbl[4].y[7] = 16'(6);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_inv = 1'b0; bus.in_tag = '0;
        bus.out_ready = 1'b1;
        hold_vld = 1'b0; lat_chk = 1'b0; use_tbl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_tag", int'(bus.out_tag), 0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_y%0d", i), int'($signed(bus.out_data[i])), 0);
        @(posedge clk);
        #1;

        // Table vectors back to back, mixed modes, latency must stay 4.
        lat_chk = 1'b1;
        use_tbl = 1'b1;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 8; i++) bus.in_data[i] = IN_W'(tbl[t].x[i]);
            bus.in_inv   = tbl[t].inv;
            bus.in_tag   = tbl[t].tag;
            bus.in_valid = 1'b1;
            pend_exp.y   = tbl[t].y;
            tick(acc);
            check("tbl_accept", int'(acc), 1);
        end
        bus.in_valid = 1'b0;
        use_tbl = 1'b0;
        repeat (6) tick(acc);
        check("tbl_drain", q.size(), 0);

        // Unit impulses at every position (forward), then scaled impulses in alternating modes.
        for (int p = 0; p < 16; p++) begin
            bus.in_data = '0;
            bus.in_data[p % 8] = (p < 8) ? IN_W'(1) : IN_W'(200 - 37 * (p % 8));
            bus.in_inv   = (p < 8) ? 1'b0 : 1'(p % 2);
            bus.in_tag   = TAG_W'(p);
            bus.in_valid = 1'b1;
            tick(acc);
        end
        bus.in_valid = 1'b0;
        repeat (6) tick(acc);
        check("imp_drain", q.size(), 0);

        // Fill with out_ready low: exactly 4 vectors fit, then push+pop together.
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_rand(0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            tick(acc);
            if (acc) begin
                n++;
                drive_rand(n);
            end
        end
        check("fill_count", n, 4);
        check("full_in_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        tick(acc);
        check("push_pop_accept", int'(acc), 1);
        check("push_pop_occupancy", q.size(), 4);
        bus.in_valid = 1'b0;
        repeat (8) tick(acc);
        check("fill_drain", q.size(), 0);

        // Random stream under random backpressure.
        sent = 0; guard = 0; have = 1'b0;
        while ((sent < 20 || q.size() > 0) && guard < 1000) begin
            if (!have && sent < 20 && $urandom_range(0, 3) != 0) begin
                drive_rand(sent % 8);
                have = 1'b1;
            end
            bus.in_valid  = have;
            bus.out_ready = 1'($urandom_range(0, 1));
            tick(acc);
            if (acc) begin
                have = 1'b0;
                sent++;
            end
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("rand_sent", sent, 20);
        check("rand_drain", q.size(), 0);

        // Reset with three vectors in flight.
        for (int c = 0; c < 3; c++) begin
            drive_rand(c);
            bus.in_valid = 1'b1;
            tick(acc);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        #2;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        q.delete();
        hold_vld = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("post_rst_valid", int'(bus.out_valid), 0);
            #1;
            tick(acc);
        end
        check("post_rst_in_ready", int'(bus.in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dct8_pipe.md
Name: dct8_pipe

Overview:
- Pipelined, parametrised 8-point 1-D DCT-II / IDCT engine for the JPEG datapath. Processes one 8-sample row or column vector per cycle.
- Sits between the level-shift/block-buffer stage and the transpose buffer. Two instances, row pass then column pass, form the 2-D transform.
- Replaces the earlier combinational butterfly with:
  - bit-exact fixed-point arithmetic,
  - a per-vector forward/inverse mode,
  - a valid/ready handshake with backpressure,
  - a sideband tag.

Parameters:
IN_W, 9, signed input sample width in bits
OUT_W, 12, signed output coefficient width in bits (saturated)
COEF_FRAC, 12, fractional bits of the integer cosine table
TAG_W, 3, width of the sideband tag carried alongside each vector

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block accepts a vector this cycle
in_data  in  8 x IN_W signed  samples x[0..7]
in_inv  in  1  0 = forward DCT, 1 = inverse DCT for this vector
in_tag  in  TAG_W  sideband, e.g. row index
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts
out_data  out  8 x OUT_W signed  results y[0..7]
out_tag  out  TAG_W  tag of the vector in out_data

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Coefficient table C[k][n], for k, n in 0..7:
  - C[k][n] = round_half_away(2^COEF_FRAC * a(k)/2 * cos((2n+1)kπ/16)).
  - a(0) = 1/√2; a(k>0) = 1.
  - Constant table, computed at elaboration. For COEF_FRAC=12: C[0][*] = 1448.
- Forward (inv=0): acc[k] = Σn x[n]*C[k][n].
- Inverse (inv=1): acc[n] = Σk x[k]*C[k][n], i.e. the transpose.
- Accumulator is signed, at least IN_W+COEF_FRAC+4 bits wide; no intermediate truncation.
- Output formation:
  - y = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (arithmetic shift).
  - Then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Pipeline:
  - Exactly 4 register stages.
  - A vector accepted at cycle t appears on out_data with out_valid=1 at cycle t+4 when there is no stall.
  - Suggested split: S1 input capture, S2 products, S3 partial sums, S4 round/saturate. Internal split is free; latency and bit-exactness are not.
- Mode and tag:
  - in_inv and in_tag are captured with the vector and travel with it.
  - Consecutive vectors may alternate mode with no bubble.
- Handshake:
  - en = !out_valid || out_ready; in_ready = en.
  - When en=0 every stage holds its contents, including out_data/out_tag.
  - Transfer occurs on in_valid && in_ready, or on out_valid && out_ready.
  - in_ready has no combinational dependency on in_valid.
  - Each stage has its own valid bit; bubbles propagate.
- Reset: out_valid=0, all stage valids=0, out_data=0, out_tag=0. in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight vectors are discarded; nothing is emitted after rst deasserts.
- Throughput: one vector per cycle with out_ready held high. The pipeline holds 4 vectors in flight with no loss under arbitrary out_ready toggling.
- Simultaneous output pop and input push while full: both transfers occur and occupancy is unchanged.

Decomposition:
- Package dct_pkg:
  - COEF_FRAC default and C table generator function.
  - typedefs for the sample vector and the accumulator vector.
  - saturate function.
- Sub-module dct8_mac_row: one output lane, 8 products + adder tree + round/saturate, with coefficient row selected by mode.
  - Instanced 8 times.
  - Stage enables come from the top.

Test Plan:
1. Forward, all x=100, inv=0 -> y[0]=283, y[1..7]=0, out_valid exactly 4 cycles after acceptance, tag preserved.
2. Inverse, x=[283,0,0,0,0,0,0,0], inv=1 -> all y=100. Back-to-back with test 1's vector: no bubble, correct mode per vector.
3. Saturation, OUT_W=10, forward, all x=255 -> y[0]=511 (raw 721 clipped), others 0. All x=-256 -> y[0]=-512.
4. Backpressure:
   - Stream 20 random vectors with tags 0..7 cycling, out_ready random 50%.
   - Outputs must match the software model in order, with no drops or duplicates.
   - out_data must be stable while out_valid && !out_ready.
5. Reset mid-stream: assert rst with 3 vectors in flight -> out_valid=0 the next cycle, no stale output afterwards, in_ready=1.
6. Alternating impulses x[n]=1 at each n, forward, COEF_FRAC=12 -> y[k] = round((C[k][n]+2048)>>12). Compared bit-exact against the model for all 8 n.
